// File: rtl/req_ser_pkg.sv
// Shared definitions for the req/ack serializer and its matching deserializer.
package req_ser_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_t;

  // Beats per word for a beat-count field of nw bits.
  function automatic int beats_of(input int nw);
    return 1 << nw;
  endfunction

endpackage

// File: rtl/req_ser.sv
// Wide-word to narrow-beat serializer: accepts one word on d_in/req_in/ack_in and
// emits beats LSB-first on d_out/req_out/ack_out with a last-beat marker.
//
// Handshake: on both channels a transfer happens at a rising edge where req and
// ack are both high; a raised req holds its payload stable until that edge, and
// ack may depend combinationally on the partner's req (here ack_in follows ack_out).
module req_ser
  import req_ser_pkg::*;
#(
  parameter int dw = 8,
  parameter int NW = 2
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [beats_of(NW)*dw-1:0]  d_in,
  input  logic [NW-1:0]               len_in,
  input  logic                        req_in,
  output logic                        ack_in,
  output logic [dw-1:0]               d_out,
  output logic                        last_out,
  output logic                        req_out,
  input  logic                        ack_out,
  output logic                        dbg_state
);

  localparam int N = beats_of(NW);

  ser_state_t          state_q, state_d;
  logic [N*dw-1:0]     sh_q, sh_d;
  logic [NW-1:0]       cnt_q, cnt_d;
  logic                accept;
  logic                xfer;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    req_out   = (state_q == ST_SEND);
    last_out  = (state_q == ST_SEND) && (cnt_q == '0);
    d_out     = sh_q[dw-1:0];
    ack_in    = (state_q == ST_IDLE) || (last_out && ack_out);
    accept    = req_in && ack_in;
    xfer      = req_out && ack_out;
    dbg_state = state_q;

    // A new word landing on the final beat's edge keeps the stream gap-free.
    if (accept) begin
      sh_d    = d_in;
      cnt_d   = len_in;
      state_d = ST_SEND;
    end else if (xfer) begin
      if (last_out) begin
        state_d = ST_IDLE;
      end else begin
        sh_d  = sh_q >> dw;
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_req_ser.sv
// Randomized and directed bench for req_ser with a beat-queue scoreboard.
module tb_req_ser;

  localparam int DW = 8;
  localparam int NW = 2;
  localparam int N  = 1 << NW;

  logic              clk;
  logic              rstn;
  logic [N*DW-1:0]   d_in;
  logic [NW-1:0]     len_in;
  logic              req_in;
  logic              ack_in;
  logic [DW-1:0]     d_out;
  logic              last_out;
  logic              req_out;
  logic              ack_out;
  logic              dbg_state;

  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;
  bit mon_en = 0;

  // Expected beats of the word currently held: {last, data}.
  logic [DW:0] exp_q[$];

  req_ser #(.dw(DW), .NW(NW)) dut (
    .clk(clk), .rstn(rstn), .d_in(d_in), .len_in(len_in), .req_in(req_in),
    .ack_in(ack_in), .d_out(d_out), .last_out(last_out), .req_out(req_out),
    .ack_out(ack_out), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: one cycle of inputs, driven on the falling edge and sampled just
  // before the rising edge; an accepted word is expanded into expected beats.
  task automatic cycle(input logic r, input logic [N*DW-1:0] d, input logic [NW-1:0] l,
                       input logic a, output logic acc);
    @(negedge clk);
    req_in  = r;
    d_in    = d;
    len_in  = l;
    ack_out = a;
    #4;
    acc = req_in & ack_in;
    if (acc) begin
      for (int k = 0; k <= int'(l); k++)
        exp_q.push_back({(k == int'(l)), d[k*DW +: DW]});
    end
  endtask

  task automatic idle(input logic a);
    logic acc;
    cycle(1'b0, '0, '0, a, acc);
  endtask

  task automatic send_word(input logic [N*DW-1:0] d, input logic [NW-1:0] l,
                           input logic a, output int waited);
    logic acc;
    waited = 0;
    acc = 1'b0;
    while (!acc && waited < 50) begin
      cycle(1'b1, d, l, a, acc);
      waited++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no ack_in expected accept within 50 cycles");
    end
  endtask

  // Monitor: compares presented beats with the queue head and pops on transfer.
  always begin
    @(negedge clk);
    #2;
    if (mon_en && rstn) begin
      check("req_out", req_out, exp_q.size() != 0);
      check("ack_in", ack_in, (exp_q.size() == 0) || (exp_q.size() == 1 && ack_out));
      if (req_out && exp_q.size() != 0) begin
        check("beat", {last_out, d_out}, exp_q[0]);
        if (ack_out) begin
          void'(exp_q.pop_front());
          xfer_cnt++;
        end
      end
    end
  end

  initial begin
    int w;
    int base;
    logic acc;
    rstn = 1'b0; req_in = 1'b0; d_in = '0; len_in = '0; ack_out = 1'b0;
    #1;
    check("rst_ack_in", ack_in, 1);
    check("rst_req_out", req_out, 0);
    check("rst_d_out", d_out, 0);
    check("rst_last_out", last_out, 0);
    @(negedge clk);
    rstn = 1'b1;
    mon_en = 1;
    idle(1'b1);
    check("idle_ack_in", ack_in, 1);

    // Single 4-beat word with ack_out high: four transfers on four edges.
    send_word(32'h44332211, 2'd3, 1'b1, w);
    base = xfer_cnt;
    repeat (4) idle(1'b1);
    check("single_xfers", xfer_cnt - base, 4);
    repeat (2) idle(1'b1);
    check("single_drained", exp_q.size(), 0);

    // One-beat word: only 0xAA appears.
    send_word(32'hDDCCBBAA, 2'd0, 1'b1, w);
    base = xfer_cnt;
    repeat (3) idle(1'b1);
    check("len0_xfers", xfer_cnt - base, 1);

    // Backpressure pattern.
    send_word(32'h44332211, 2'd3, 1'b0, w);
    base = xfer_cnt;
    begin
      logic [6:0] pat;
      pat = 7'b1101001; // applied LSB first: 1,0,0,1,0,1,1
      for (int i = 0; i < 7; i++) idle(pat[i]);
    end
    repeat (3) idle(1'b0);
    check("bp_xfers", xfer_cnt - base, 4);
    check("bp_drained", exp_q.size(), 0);

    // Back-to-back: B accepted on A's last-beat edge, six beats on six edges.
    send_word(32'h44332211, 2'd3, 1'b1, w);
    base = xfer_cnt;
    send_word(32'h00008877, 2'd1, 1'b1, w);
    check("b2b_accept_wait", w, 4);
    repeat (2) idle(1'b1);
    check("b2b_xfers", xfer_cnt - base, 6);
    idle(1'b1);
    check("b2b_drained", exp_q.size(), 0);

    // Reset during beat 2 of a 4-beat word.
    send_word(32'h44332211, 2'd3, 1'b1, w);
    repeat (2) idle(1'b1);
    mon_en = 0;
    check("pre_rst_req_out", req_out, 1);
    rstn = 1'b0;
    #1;
    check("mid_rst_req_out", req_out, 0);
    check("mid_rst_ack_in", ack_in, 1);
    check("mid_rst_d_out", d_out, 0);
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    mon_en = 1;
    idle(1'b0);
    check("post_rst_req_out", req_out, 0);
    check("post_rst_state", dbg_state, 0);

    // Random soak.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 1) == 1), {$urandom, $urandom} , NW'($urandom_range(0, N-1)),
            ($urandom_range(0, 9) < 7), acc);
    end
    repeat (8) idle(1'b1);
    check("soak_drained", exp_q.size(), 0);
    check("soak_idle", req_out, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/req_ser.md
# req_ser

Parallel-to-serial transmitter on the team's req/ack handshake channel. Accepts one wide word of N beats on its input port and drives the beats, least-significant first, onto a narrow req/ack output with a last-beat marker. Sits upstream of the narrow FIFOs, acting as the sending end of their input channel. Sustains one beat per cycle with no bubble between consecutive words.

## Interface
- `dw`, 8: beat width in bits.
- `NW`, 2: beat-count width; N = 2**NW beats per word.
- `clk` input 1: clock; all state changes on the rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `d_in` input N*dw: wide word; beat k is `d_in[k*dw +: dw]`.
- `len_in` input NW: number of beats in the word minus 1 (0 means 1 beat, N-1 means N beats); sampled with `d_in`.
- `req_in` input 1: upstream word valid.
- `ack_in` output 1: word accepted when `req_in & ack_in` at a rising edge.
- `d_out` output dw: current beat.
- `last_out` output 1: current beat is the final beat of its word.
- `req_out` output 1: beat valid.
- `ack_out` input 1: beat consumed when `req_out & ack_out` at a rising edge.

## Operation
- State register has two states:
  - IDLE: holding nothing.
  - SEND: holding a word, with `cnt` beats remaining after the current one.
- Datapath registers: `sh` (N*dw shift register), `cnt` (NW bits).
- `d_out = sh[dw-1:0]`.
- `req_out = (state == SEND)`.
- `last_out = (state == SEND) & (cnt == 0)`.
- `ack_in = (state == IDLE) | (last_out & ack_out)`. This is a combinational path from `ack_out` to `ack_in` and is intended.
- Accept (`req_in & ack_in`):
  - `sh <= d_in`, `cnt <= len_in`, state <= SEND.
  - Takes priority over the beat-advance shift in the same cycle.
- Beat transfer without accept (`req_out & ack_out`, not last):
  - `sh <= sh >> dw` (zero fill), `cnt <= cnt - 1`.
- Last beat transfer without a new accept: state <= IDLE; `sh` and `cnt` hold.
- SEND with `ack_out` low: all registers hold. `d_out`, `last_out` and `req_out` stay stable until the beat is taken.
- `req_in` while in SEND and not on a consumed last beat is ignored; `ack_in` is low.
- `cnt` never wraps: it is decremented only while nonzero.
- Upper beats beyond `len_in` are never presented.

## Timing
- Reset values: state IDLE, `sh` 0, `cnt` 0. Outputs: `req_out` 0, `last_out` 0, `d_out` 0, `ack_in` 1.
- Reset asserted mid-word discards the word. Outputs return to their reset values immediately (asynchronously).
- Latency: a word accepted at edge t presents beat 0 in the cycle after t.
- A word of `len_in`+1 beats with `ack_out` held high occupies exactly `len_in`+1 cycles.
- Back-to-back words: the last beat of word A and the accept of word B happen at the same edge. Beat 0 of B follows with no idle cycle. Throughput is 1 beat/cycle.
- `req_out` never deasserts without a completed transfer, except by reset.

## Structure
- Shared package holds:
  - state encodings `ST_IDLE = 1'b0`, `ST_SEND = 1'b1`;
  - a helper constant for beat count N derived from `NW`.
- Single module; no sub-module. The shift register and counter are small enough to stay inline.
- Matching deserializer (`req_deser`) is out of scope but will reuse the same package.

## Test plan
- Reset, then idle:
  - `ack_in`=1, `req_out`=0, `d_out`=0.
  - Assert `rstn`=0 during beat 2 of a 4-beat word: `req_out` drops immediately; after release the block is IDLE.
- Single 4-beat word, dw=8, `d_in`=0x44332211, `len_in`=3, `ack_out`=1:
  - beats 0x11, 0x22, 0x33, 0x44 on four consecutive cycles;
  - `last_out` only on 0x44;
  - `ack_in`=0 during beats 0x11–0x33.
- `len_in`=0, `d_in`=0xDDCCBBAA: one beat 0xAA with `last_out`=1; 0xBB never appears.
- Backpressure: same word with `ack_out` toggling 1,0,0,1,0,1,1. Each beat is held stable through stall cycles; exactly 4 transfers occur; order 0x11..0x44.
- Back-to-back: words 0x44332211 (len 3) then 0x00008877 (len 1) with `req_in`, `ack_out` high throughout:
  - 6 consecutive beats 11,22,33,44,77,88;
  - `last_out` on 44 and 88;
  - no gap cycle.
- Random soak against a scoreboard with random `req_in`/`ack_out`/`len_in`:
  - every accepted word is emitted exactly once, in order, with correct beat count;
  - `req_out` never drops mid-beat.
